// File: rtl/rpn_tokenizer_if.sv
// Byte-in / command-out bundle between the UART receiver, the tokenizer and the rpn core.
//   rx_valid, rx_data : one-cycle byte strobe and received ASCII byte (into the tokenizer)
//   num_en, num       : one-cycle literal pulse and completed decimal value
//   op_en, op         : one-cycle operator pulse and operator code
//   err               : one-cycle pulse on an unrecognised byte or an overrun
// Modports: slave is the tokenizer side, master is the side that feeds bytes and takes commands.
interface rpn_tokenizer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 4
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              num_en;
  logic [DATA_W-1:0] num;
  logic              op_en;
  logic [OP_W-1:0]   op;
  logic              err;

  modport slave (
    input  rx_valid,
    input  rx_data,
    output num_en,
    output num,
    output op_en,
    output op,
    output err
  );

  modport master (
    output rx_valid,
    output rx_data,
    input  num_en,
    input  num,
    input  op_en,
    input  op,
    input  err
  );
endinterface

// File: rtl/rpn_tokenizer.sv
// ASCII-to-command front-end for the rpn stack computer.
// Turns a byte stream such as "12 2+2*=" into num_en/num and op_en/op strobes, literal
// first when an operator directly terminates a literal. Flags bad bytes and overruns on err.
// Ports:
//   clk   : system clock, all logic on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : rpn_tokenizer_if slave (rx_valid/rx_data in; num_en/num/op_en/op/err out)
// All outputs are registered: a byte accepted at edge N is answered in the cycle after N.
module rpn_tokenizer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 4
) (
  input logic            clk,
  input logic            rst_n,
  rpn_tokenizer_if.slave bus
);

  localparam logic [OP_W-1:0] OpAdd     = OP_W'(0);
  localparam logic [OP_W-1:0] OpSub     = OP_W'(1);
  localparam logic [OP_W-1:0] OpMul     = OP_W'(2);
  localparam logic [OP_W-1:0] OpDiv     = OP_W'(3);
  localparam logic [OP_W-1:0] OpPop     = OP_W'(4);
  localparam logic [OP_W-1:0] OpUnknown = OP_W'(4'hF);

  typedef enum logic [1:0] {StIdle, StNum, StOpq} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [OP_W-1:0]   opq_q, opq_d;    // operator queued behind a just-emitted literal
  logic              num_en_q, num_en_d;
  logic [DATA_W-1:0] num_q, num_d;
  logic              op_en_q, op_en_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              err_q, err_d;

  // Byte classification
  logic              is_digit, is_delim, is_op;
  logic [OP_W-1:0]   op_code;
  logic [DATA_W-1:0] digit_ext;
  logic [DATA_W-1:0] acc_next;

  always_comb begin
    is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    is_delim = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    is_op    = 1'b1;
    op_code  = OpUnknown;
    case (bus.rx_data)
      8'h2B:   op_code = OpAdd;  // '+'
      8'h2D:   op_code = OpSub;  // '-'
      8'h2A:   op_code = OpMul;  // '*'
      8'h2F:   op_code = OpDiv;  // '/'
      8'h3D:   op_code = OpPop;  // '='
      default: is_op   = 1'b0;
    endcase
  end

  // acc*10 + digit as shift-adds; the sum wraps modulo 2^DATA_W by construction
  assign digit_ext = {{(DATA_W-4){1'b0}}, bus.rx_data[3:0]};
  assign acc_next  = (acc_q << 3) + (acc_q << 1) + digit_ext;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid && is_digit) state_d = StNum;
      end
      StNum: begin
        if (bus.rx_valid) begin
          if (is_digit)   state_d = StNum;
          else if (is_op) state_d = StOpq;
          else            state_d = StIdle;  // delimiter or bad byte
        end
      end
      StOpq:   state_d = StIdle;  // lasts exactly one cycle regardless of input
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-values
  always_comb begin
    acc_d    = acc_q;
    opq_d    = opq_q;
    num_en_d = 1'b0;
    num_d    = num_q;
    op_en_d  = 1'b0;
    op_d     = op_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid) begin
          if (is_digit) begin
            acc_d = digit_ext;  // fresh literal starts from zero
          end else if (is_op) begin
            op_en_d = 1'b1;
            op_d    = op_code;
          end else if (!is_delim) begin
            err_d = 1'b1;
          end
        end
      end
      StNum: begin
        if (bus.rx_valid) begin
          if (is_digit) begin
            acc_d = acc_next;
          end else if (is_delim || is_op) begin
            num_en_d = 1'b1;
            num_d    = acc_q;
            acc_d    = '0;
            if (is_op) opq_d = op_code;
          end else begin
            // Bad byte: drop the partial literal silently apart from err
            err_d = 1'b1;
            acc_d = '0;
          end
        end
      end
      StOpq: begin
        op_en_d = 1'b1;
        op_d    = opq_q;
        // No slot to process a byte here; it is lost and reported as an overrun
        if (bus.rx_valid) err_d = 1'b1;
      end
      default: begin
        acc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opq_q    <= OpUnknown;
      num_en_q <= 1'b0;
      num_q    <= '0;
      op_en_q  <= 1'b0;
      op_q     <= OpUnknown;
      err_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opq_q    <= opq_d;
      num_en_q <= num_en_d;
      num_q    <= num_d;
      op_en_q  <= op_en_d;
      op_q     <= op_d;
      err_q    <= err_d;
    end
  end

  assign bus.num_en = num_en_q;
  assign bus.num    = num_q;
  assign bus.op_en  = op_en_q;
  assign bus.op     = op_q;
  assign bus.err    = err_q;

endmodule

// File: doc/rpn_tokenizer.md
Name: rpn_tokenizer

Overview:
Upstream front-end for the rpn stack computer. Consumes ASCII bytes from the UART receiver (one-cycle rx_valid strobe per byte) and converts them into the computer's command strobes: num_en/num for decimal literals and op_en/op for operators. Turns a typed line such as "12 2+2*=" into the exact num/op pulse sequence the rpn core expects. Also flags malformed input.

Parameters:
DATA_W  16  width of num output; decimal accumulation is modulo 2^DATA_W
OP_W  4  width of op output

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
rx_data  in  8  received ASCII byte
num_en  out  1  one-cycle pulse, num valid
num  out  DATA_W  completed decimal literal
op_en  out  1  one-cycle pulse, op valid
op  out  OP_W  operator code: ADD=0, SUB=1, MUL=2, DIV=3, POP=4, UNKNOWN=4'hF
err  out  1  one-cycle pulse on unrecognised byte or overrun

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, accumulator=0, num_en=0, op_en=0, err=0, num=0, op=4'hF. Reset mid-literal discards the partial literal and any pending op, with no pulse emitted.
- All outputs are registered. Response to a byte accepted at edge N appears in the cycle after N.
- States:
  - IDLE: no literal in progress.
  - NUM: accumulating digits.
  - OPQ: an operator is queued behind a just-emitted literal.
- Byte classes:
  - digit '0'-'9' (0x30-0x39): acc <= acc*10 + (byte-0x30), truncated to DATA_W bits (wraps silently). IDLE->NUM, with acc starting from 0. NUM->NUM.
  - delimiter ' ' (0x20), CR (0x0D), LF (0x0A): in NUM, emit num_en=1 with num=acc, clear acc, go to IDLE. In IDLE, ignored with no pulse.
  - operator '+'->0, '-'->1, '*'->2, '/'->3, '='->4:
    - In IDLE: op_en=1, op=code next cycle; stay in IDLE.
    - In NUM: emit num_en/num first, latch code, go to OPQ. Next cycle emit op_en/op and go to IDLE. The literal and operator therefore pulse on consecutive cycles, literal first.
  - any other byte: err=1 for one cycle. Any partial literal is discarded (acc cleared), no num_en is issued, and the state goes to IDLE.
- num_en and op_en are never high in the same cycle.
- OPQ lasts exactly one cycle and emits the queued op unconditionally. A byte arriving while in OPQ is dropped and raises err=1 in the following cycle. The queued op is still emitted.
- num and op hold their last emitted value between pulses. op returns to 4'hF only on reset.
- Minimum byte spacing for loss-free operation is 2 cycles. The UART byte period is far larger.
- '-' is always SUB; there are no signed literals. Literal "0" emits num=0. Leading zeros are accepted ("007" -> 7).

Test Plan:
- Byte stream "12 2+2*=" with 4-cycle spacing -> pulses in order: num=12, num=2, op=0, num=2, op=2, op=4. num_en and op_en are never coincident.
- "7+" with 4-cycle spacing -> num_en with num=7 in the cycle after '+' is accepted; op_en with op=0 in the next cycle; state back to IDLE.
- "65537 " -> single num_en with num=1 (wrap modulo 65536); err stays 0.
- "1x3 " -> err pulse one cycle after 'x'; num_en with num=3 after the space; no pulse for "1".
- "5*" then 'A' sent one cycle after '*' (during OPQ) -> num=5 pulse, then op=2 pulse, then err pulse; 'A' has no other effect.
- "42" then rst_n=0 for one edge, then " " -> no num_en at all; outputs at reset values (op=4'hF).
